// File: rtl/ex_mem_wb_pipe_if.sv
// Data-memory bus between the EX/MEM stage and a combinational-read memory.
// The pipeline drives the master side; the memory drives the slave side.
interface ex_mem_wb_pipe_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with stall/flush control and load-data select.
// Optional feature: define RETIRE_COUNT_EN to add the 16-bit retire_count output.
module ex_mem_wb_pipe (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     ex_valid,
    input  logic                     ex_regWrite,
    input  logic                     ex_memToReg,
    input  logic                     ex_memWrite,
    input  logic [3:0]               ex_registerRD,
    input  logic [31:0]              ex_aluResult,
    input  logic [31:0]              ex_storeData,
    ex_mem_wb_pipe_if.master         mem,
    output logic                     ex_mem_regWrite,
    output logic [3:0]               ex_mem_registerRD,
    output logic [31:0]              ex_mem_aluResult,
    output logic                     mem_wb_regWrite,
    output logic [3:0]               mem_wb_registerRD,
    output logic [31:0]              mem_wb_writeData
`ifdef RETIRE_COUNT_EN
    ,
    output logic [15:0]              retire_count
`endif
);

    logic        em_valid;
    logic        em_regWrite;
    logic        em_memToReg;
    logic        em_memWrite;
    logic [3:0]  em_rd;
    logic [31:0] em_alu;
    logic [31:0] em_sd;

    logic        wb_valid;
    logic        wb_regWrite;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    // A stall freezes both stages and masks flush; flush only bubbles EX/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_valid    <= 1'b0;
            em_regWrite <= 1'b0;
            em_memToReg <= 1'b0;
            em_memWrite <= 1'b0;
            em_rd       <= 4'd0;
            em_alu      <= 32'd0;
            em_sd       <= 32'd0;
        end else if (!stall) begin
            if (flush) begin
                em_valid    <= 1'b0;
                em_regWrite <= 1'b0;
                em_memToReg <= 1'b0;
                em_memWrite <= 1'b0;
                em_rd       <= 4'd0;
                em_alu      <= 32'd0;
                em_sd       <= 32'd0;
            end else begin
                em_valid    <= ex_valid;
                em_regWrite <= ex_regWrite;
                em_memToReg <= ex_memToReg;
                em_memWrite <= ex_memWrite;
                em_rd       <= ex_registerRD;
                em_alu      <= ex_aluResult;
                em_sd       <= ex_storeData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_rd       <= 4'd0;
            wb_data     <= 32'd0;
        end else if (!stall) begin
            wb_valid    <= em_valid;
            wb_regWrite <= em_regWrite;
            wb_rd       <= em_rd;
            wb_data     <= em_memToReg ? mem.mem_rdata : em_alu;
        end
    end

    // Write enables are qualified by valid so bubbles never write anything.
    assign mem.mem_addr      = em_alu;
    assign mem.mem_wdata     = em_sd;
    assign mem.mem_we        = em_memWrite & em_valid;

    assign ex_mem_regWrite   = em_regWrite & em_valid;
    assign ex_mem_registerRD = em_rd;
    assign ex_mem_aluResult  = em_alu;
    assign mem_wb_regWrite   = wb_regWrite & wb_valid;
    assign mem_wb_registerRD = wb_rd;
    assign mem_wb_writeData  = wb_data;

`ifdef RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= 16'd0;
        end else if (!stall && wb_valid) begin
            retire_count <= retire_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Randomized and directed bench for ex_mem_wb_pipe: a reference model pushes expected
// outputs at every clock edge and a monitor compares them half a cycle later.
module tb_ex_mem_wb_pipe;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic        ex_regWrite;
    logic        ex_memToReg;
    logic        ex_memWrite;
    logic [3:0]  ex_registerRD;
    logic [31:0] ex_aluResult;
    logic [31:0] ex_storeData;
    logic        ex_mem_regWrite;
    logic [3:0]  ex_mem_registerRD;
    logic [31:0] ex_mem_aluResult;
    logic        mem_wb_regWrite;
    logic [3:0]  mem_wb_registerRD;
    logic [31:0] mem_wb_writeData;
    logic [15:0] retire_count;

    ex_mem_wb_pipe_if bus ();

    ex_mem_wb_pipe dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .ex_valid          (ex_valid),
        .ex_regWrite       (ex_regWrite),
        .ex_memToReg       (ex_memToReg),
        .ex_memWrite       (ex_memWrite),
        .ex_registerRD     (ex_registerRD),
        .ex_aluResult      (ex_aluResult),
        .ex_storeData      (ex_storeData),
        .mem               (bus.master),
        .ex_mem_regWrite   (ex_mem_regWrite),
        .ex_mem_registerRD (ex_mem_registerRD),
        .ex_mem_aluResult  (ex_mem_aluResult),
        .mem_wb_regWrite   (mem_wb_regWrite),
        .mem_wb_registerRD (mem_wb_registerRD),
        .mem_wb_writeData  (mem_wb_writeData)
`ifdef RETIRE_COUNT_EN
        ,
        .retire_count      (retire_count)
`endif
    );

`ifndef RETIRE_COUNT_EN
    assign retire_count = 16'd0;
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        if (addr == 32'h40) return 32'hCAFEBABE;
        return {addr[15:0] ^ 16'h5A3C, ~addr[31:16]} + 32'h0101_0101;
    endfunction

    assign bus.mem_rdata = mem_read(bus.mem_addr);

    // ---------------- reference model ----------------
    typedef struct {
        logic        v, rw, m2r, mw;
        logic [3:0]  rd;
        logic [31:0] alu, sd;
    } instr_t;

    typedef struct {
        logic        v, rw;
        logic [3:0]  rd;
        logic [31:0] wd;
    } retire_t;

    typedef struct packed {
        logic [15:0] retire;
        logic        em_rw;
        logic [3:0]  em_rd;
        logic [31:0] em_alu;
        logic [31:0] em_sd;
        logic        we;
        logic        wb_rw;
        logic [3:0]  wb_rd;
        logic [31:0] wb_wd;
    } out_t;

    localparam int W = $bits(out_t);

    instr_t  at_mem;
    retire_t at_wb;
    int      retired;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic instr_t empty_instr();
        instr_t i;
        i = '{v: 1'b0, rw: 1'b0, m2r: 1'b0, mw: 1'b0, rd: 4'd0, alu: 32'd0, sd: 32'd0};
        return i;
    endfunction

    task automatic model_clear();
        at_mem  = empty_instr();
        at_wb   = '{v: 1'b0, rw: 1'b0, rd: 4'd0, wd: 32'd0};
        retired = 0;
    endtask

    // What the pipeline should hold after the edge that just happened.
    task automatic model_edge();
        instr_t incoming;
        if (!rst_n) begin
            model_clear();
        end else if (!stall) begin
            if (at_wb.v) retired = (retired + 1) % 65536;
            at_wb.v  = at_mem.v;
            at_wb.rw = at_mem.rw;
            at_wb.rd = at_mem.rd;
            at_wb.wd = at_mem.m2r ? mem_read(at_mem.alu) : at_mem.alu;
            incoming = '{v: ex_valid, rw: ex_regWrite, m2r: ex_memToReg, mw: ex_memWrite,
                         rd: ex_registerRD, alu: ex_aluResult, sd: ex_storeData};
            at_mem = flush ? empty_instr() : incoming;
        end
    endtask

    function automatic out_t expected_outputs();
        out_t e;
        e.retire = retired[15:0];
        e.em_rw  = at_mem.v && at_mem.rw;
        e.em_rd  = at_mem.rd;
        e.em_alu = at_mem.alu;
        e.em_sd  = at_mem.sd;
        e.we     = at_mem.v && at_mem.mw;
        e.wb_rw  = at_wb.v && at_wb.rw;
        e.wb_rd  = at_wb.rd;
        e.wb_wd  = at_wb.wd;
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = out_t'(exp_q.pop_front());
                check("ex_mem_regWrite",   {31'd0, ex_mem_regWrite}, {31'd0, e.em_rw});
                check("ex_mem_registerRD", {28'd0, ex_mem_registerRD}, {28'd0, e.em_rd});
                check("ex_mem_aluResult",  ex_mem_aluResult, e.em_alu);
                check("mem_addr",          bus.mem_addr, e.em_alu);
                check("mem_wdata",         bus.mem_wdata, e.em_sd);
                check("mem_we",            {31'd0, bus.mem_we}, {31'd0, e.we});
                check("mem_wb_regWrite",   {31'd0, mem_wb_regWrite}, {31'd0, e.wb_rw});
                check("mem_wb_registerRD", {28'd0, mem_wb_registerRD}, {28'd0, e.wb_rd});
                check("mem_wb_writeData",  mem_wb_writeData, e.wb_wd);
`ifdef RETIRE_COUNT_EN
                check("retire_count",      {16'd0, retire_count}, {16'd0, e.retire});
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        exp_q.push_back(W'(expected_outputs()));
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic mw,
                          input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        ex_valid      = v;
        ex_regWrite   = rw;
        ex_memToReg   = m2r;
        ex_memWrite   = mw;
        ex_registerRD = rd;
        ex_aluResult  = alu;
        ex_storeData  = sd;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic set_random();
        set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom(), $urandom());
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, ":ex_mem_regWrite"}, {31'd0, ex_mem_regWrite}, 32'd0);
        check({tag, ":mem_wb_regWrite"}, {31'd0, mem_wb_regWrite}, 32'd0);
        check({tag, ":mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, ":mem_wb_writeData"}, mem_wb_writeData, 32'd0);
        check({tag, ":ex_mem_aluResult"}, ex_mem_aluResult, 32'd0);
`ifdef RETIRE_COUNT_EN
        check({tag, ":retire_count"}, {16'd0, retire_count}, 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_idle();
        model_clear();
        #2;
        check_all_clear("reset");
        step();
        step();
        rst_n = 1'b1;

        // ALU result reaches EX/MEM after one edge, MEM/WB after two
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h1234, 32'd0);
        step();
        set_idle();
        check("alu:ex_mem_registerRD", {28'd0, ex_mem_registerRD}, 32'd5);
        step();
        check("alu:mem_wb_writeData", mem_wb_writeData, 32'h0000_1234);
        step();

        // Load selects memory read data
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 32'h40, 32'd0);
        step();
        set_idle();
        check("load:mem_addr", bus.mem_addr, 32'h40);
        step();
        check("load:mem_wb_writeData", mem_wb_writeData, 32'hCAFEBABE);
        step();

        // Store held across a three-cycle stall
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h100, 32'hA5A5A5A5);
        step();
        set_idle();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        step();
        step();

        // Flush bubbles the incoming instruction; the older one still advances
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h99, 32'd0);
        step();
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 32'hAA, 32'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_idle();
        step();
        step();

        // Asynchronous reset during a stall discards both in-flight instructions
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h11, 32'd0);
        step();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h22, 32'd0);
        step();
        set_idle();
        stall = 1'b1;
        step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_clear("async_reset");
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (3) step();

        // Randomized traffic with stalls and flushes
        for (int i = 0; i < 400; i++) begin
            set_random();
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 6) == 0;
            step();
        end
        stall = 1'b0;
        flush = 1'b0;

`ifdef RETIRE_COUNT_EN
        // Drive the counter to its top value, then one more retire wraps it
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h4, 32'd0);
        for (int i = 0; i < 70000 && retired != 65535; i++) step();
        check("wrap:reached_top", retired, 65535);
        step();
        check("wrap:retire_count", {16'd0, retire_count}, 32'd0);
        step();
`endif

        set_idle();
        step();
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
